// File: rtl/zerosoc_pad_pkg.sv
// -----------------------------------------------------------------------------
// zerosoc_pad_pkg
// Shared pad-ring constants for the zerosoc core top and the pad input
// conditioning stage.
//   - GpioWidth / PadInWidth / UartRxIdx : layout of the conditioned input bus
//   - PadInResetVal                      : reset level of every input bit
//                                          (uart_rx idles high, gpio low)
//   - pad-index map                      : where the we/no/ea/so din bits land
//                                          on the gpio index space
// -----------------------------------------------------------------------------
package zerosoc_pad_pkg;

    localparam int unsigned GpioWidth  = 32;
    localparam int unsigned PadInWidth = 33;
    localparam int unsigned UartRxIdx  = 32;

    localparam logic [PadInWidth-1:0] PadInResetVal = {1'b1, 32'h0000_0000};

    // Pad ring sides, in the order their din bits are concatenated.
    typedef enum logic [1:0] {
        SIDE_WE = 2'd0,
        SIDE_NO = 2'd1,
        SIDE_EA = 2'd2,
        SIDE_SO = 2'd3
    } pad_side_e;

    // Each side carries eight gpio pads; sides are packed LSB-first.
    localparam int unsigned PadsPerSide = 8;
    localparam int unsigned WeGpioLsb   = 0;
    localparam int unsigned NoGpioLsb   = 8;
    localparam int unsigned EaGpioLsb   = 16;
    localparam int unsigned SoGpioLsb   = 24;

    // Map a (side, pad offset on that side) pair onto its gpio index.
    function automatic int unsigned gpio_index(input pad_side_e side,
                                               input int unsigned offset);
        int unsigned base;
        case (side)
            SIDE_WE: base = WeGpioLsb;
            SIDE_NO: base = NoGpioLsb;
            SIDE_EA: base = EaGpioLsb;
            SIDE_SO: base = SoGpioLsb;
            default: base = WeGpioLsb;
        endcase
        return base + (offset % PadsPerSide);
    endfunction

endpackage

// File: rtl/pad_filter_bit.sv
// -----------------------------------------------------------------------------
// pad_filter_bit
// Conditions a single asynchronous pad input: SyncStages-deep synchroniser,
// stability filter requiring FilterCycles consecutive differing samples, and
// registered one-cycle rise/fall pulses aligned with the output level change.
// Ports:
//   clk_i        core clock
//   rst_i        asynchronous active-high reset
//   pad_i        raw pad input
//   filter_en_i  1 = filter active, 0 = bypass (synchroniser only)
//   din_o        conditioned level
//   rise_o       one-cycle pulse, first cycle din_o shows 1 after a 0
//   fall_o       one-cycle pulse, first cycle din_o shows 0 after a 1
// -----------------------------------------------------------------------------
module pad_filter_bit #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = 4,
    parameter logic        ResetVal     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    input  logic filter_en_i,
    output logic din_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW    = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    logic [SyncStages-1:0] sync_d, sync_q;
    logic [CntW-1:0]       cnt_d,  cnt_q;
    logic                  din_d,  din_q;
    logic                  rise_d, rise_q;
    logic                  fall_d, fall_q;
    logic                  s;

    assign s = sync_q[SyncStages-1];

    // Synchroniser shift and filter decision for the next edge.
    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], pad_i};
        din_d  = din_q;
        cnt_d  = cnt_q;
        if (!filter_en_i) begin
            din_d = s;
            cnt_d = '0;
        end else if (s == din_q) begin
            // Sample agrees with the output: any partial count was a glitch.
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            din_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        // Pulses are registered alongside din so they line up with the change.
        rise_d = din_d & ~din_q;
        fall_d = ~din_d & din_q;
    end

    // State registers; reset drops any pending count and suppresses pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SyncStages{ResetVal}};
            cnt_q  <= '0;
            din_q  <= ResetVal;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            din_q  <= din_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign din_o  = din_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/pad_in_filter.sv
// -----------------------------------------------------------------------------
// pad_in_filter
// Input-conditioning stage between the pad ring din buses and the SoC core.
// Every bit is synchronised, optionally deglitched, and edge-detected
// independently. Bits [31:0] are gpio, bit 32 is uart_rx (idles high).
// filter_en_i is a quasi-static CSR value and is used without synchronising.
// Ports:
//   clk_i        core clock
//   rst_i        asynchronous active-high reset
//   pad_din_i    raw asynchronous pad inputs
//   filter_en_i  per-bit filter enable (0 = synchroniser only)
//   din_o        conditioned levels to the core
//   rise_o       one-cycle pulse on each 0->1 change of din_o
//   fall_o       one-cycle pulse on each 1->0 change of din_o
// -----------------------------------------------------------------------------
module pad_in_filter
    import zerosoc_pad_pkg::*;
#(
    parameter int unsigned     Width        = PadInWidth,
    parameter int unsigned     SyncStages   = 2,
    parameter int unsigned     FilterCycles = 4,
    parameter logic [Width-1:0] ResetVal    = PadInResetVal
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] pad_din_i,
    input  logic [Width-1:0] filter_en_i,
    output logic [Width-1:0] din_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    for (genvar i = 0; i < Width; i++) begin : g_bit
        pad_filter_bit #(
            .SyncStages  (SyncStages),
            .FilterCycles(FilterCycles),
            .ResetVal    (ResetVal[i])
        ) u_bit (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .pad_i      (pad_din_i[i]),
            .filter_en_i(filter_en_i[i]),
            .din_o      (din_o[i]),
            .rise_o     (rise_o[i]),
            .fall_o     (fall_o[i])
        );
    end

endmodule

// File: tb/tb_pad_in_filter.sv
module tb_pad_in_filter;

    localparam logic [32:0] BASE   = 33'h1_0000_0000;
    localparam logic [32:0] ALL_EN = {33{1'b1}};
    localparam logic [32:0] BYP_EN = 33'h0_FFFF_FFFF;
    localparam logic [32:0] ZERO   = 33'h0;

    typedef struct {
        logic [32:0] pad;
        logic [32:0] en;
        logic [32:0] din;
        logic [32:0] rise;
        logic [32:0] fall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] pad;
    logic [32:0] en;
    logic [32:0] din;
    logic [32:0] rise;
    logic [32:0] fall;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    pad_in_filter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pad_din_i  (pad),
        .filter_en_i(en),
        .din_o      (din),
        .rise_o     (rise),
        .fall_o     (fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [32:0] p, input logic [32:0] e, input logic [32:0] d,
                       input logic [32:0] r, input logic [32:0] f);
        vec_t v;
        v.pad = p; v.en = e; v.din = d; v.rise = r; v.fall = f;
        vecs.push_back(v);
    endtask

    initial begin
        logic [32:0] p3, p10, p0, p5;
        int high_cnt, rise_cnt, fall_cnt;
        p3  = BASE | 33'h8;
        p10 = BASE | (33'h1 << 10);
        p0  = BASE | 33'h1;
        p5  = BASE | (33'h1 << 5);

        // Bit 3 clean edge, filtered: change shows on the 6th edge counting the sampling edge.
        for (int k = 0; k < 5; k++) add(p3, ALL_EN, BASE, ZERO, ZERO);
        add(p3, ALL_EN, p3, 33'h8, ZERO);
        add(p3, ALL_EN, p3, ZERO, ZERO);
        for (int k = 0; k < 5; k++) add(BASE, ALL_EN, p3, ZERO, ZERO);
        add(BASE, ALL_EN, BASE, ZERO, 33'h8);
        add(BASE, ALL_EN, BASE, ZERO, ZERO);
        // uart_rx bypass, toggling every 2 cycles: follows with 3-edge latency.
        add(ZERO, BYP_EN, BASE, ZERO, ZERO);
        add(ZERO, BYP_EN, BASE, ZERO, ZERO);
        add(BASE, BYP_EN, ZERO, ZERO, BASE);
        add(BASE, BYP_EN, ZERO, ZERO, ZERO);
        add(ZERO, BYP_EN, BASE, BASE, ZERO);
        add(ZERO, BYP_EN, BASE, ZERO, ZERO);
        add(BASE, BYP_EN, ZERO, ZERO, BASE);
        add(BASE, BYP_EN, ZERO, ZERO, ZERO);
        add(BASE, BYP_EN, BASE, BASE, ZERO);
        add(BASE, BYP_EN, BASE, ZERO, ZERO);

        // Reset with pads at 0: outputs hold the reset value.
        rst = 1'b1;
        pad = ZERO;
        en  = ALL_EN;
        #1;
        check("reset_async din", din, BASE);
        check("reset_async pulses", rise | fall, ZERO);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_hold din", din, BASE);
            check("reset_hold pulses", rise | fall, ZERO);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("post_reset din", din, BASE);
            check("post_reset pulses", rise | fall, ZERO);
        end
        pad = BASE;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("settle din", din, BASE);
        end

        // Table-driven vectors.
        foreach (vecs[i]) begin
            pad = vecs[i].pad;
            en  = vecs[i].en;
            tick();
            check($sformatf("vec%0d din", i), din, vecs[i].din);
            check($sformatf("vec%0d rise", i), rise, vecs[i].rise);
            check($sformatf("vec%0d fall", i), fall, vecs[i].fall);
        end
        en = ALL_EN;
        pad = BASE;
        tick();

        // Glitch of 3 synchronised cycles on bit 10 is discarded.
        pad = p10;
        for (int k = 0; k < 3; k++) tick();
        pad = BASE;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch3 din", din, BASE);
            check("glitch3 pulses", rise | fall, ZERO);
        end

        // A 4-cycle pulse is just long enough: output high for exactly 4 cycles.
        high_cnt = 0; rise_cnt = 0; fall_cnt = 0;
        pad = p10;
        for (int k = 0; k < 20; k++) begin
            if (k == 4) pad = BASE;
            tick();
            if (din[10]) high_cnt++;
            if (rise[10]) rise_cnt++;
            if (fall[10]) fall_cnt++;
            check("pulse4 other bits", din & ~(33'h1 << 10), BASE);
        end
        check("pulse4 high cycles", 33'(high_cnt), 33'd4);
        check("pulse4 rise count", 33'(rise_cnt), 33'd1);
        check("pulse4 fall count", 33'(fall_cnt), 33'd1);

        // Mode switch mid-count on bit 0: pending value taken on the bypass edge.
        pad = p0;
        for (int k = 0; k < 4; k++) tick();
        check("modesw counting din", din, BASE);
        en = ALL_EN & ~33'h1;
        tick();
        check("modesw bypass din", din, p0);
        check("modesw bypass rise", rise, 33'h1);
        en = ALL_EN;
        pad = BASE;
        for (int k = 0; k < 5; k++) tick();
        check("modesw refilter hold", din, p0);
        tick();
        check("modesw refilter din", din, BASE);
        check("modesw refilter fall", fall, 33'h1);

        // Async reset while bit 5 is counting down from high.
        pad = p5;
        for (int k = 0; k < 6; k++) tick();
        check("rst_mid raise din", din, p5);
        tick();
        pad = BASE;
        for (int k = 0; k < 4; k++) tick();
        check("rst_mid counting din", din, p5);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid async din", din, BASE);
        check("rst_mid async pulses", rise | fall, ZERO);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rst_mid after din", din, BASE);
            check("rst_mid after pulses", rise | fall, ZERO);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_in_filter.md
Name: pad_in_filter

Overview:
- Input-conditioning stage between the pad ring's `din` buses and the SoC core: synchronises every pad input into the core clock domain, rejects glitches, and reports clean edges.
- Consumes the concatenated we/no/ea/so `din` bits that carry gpio and uart_rx.
- Drives the core's `gpio_i` and `uart_rx_i` with stable, deglitched levels, plus one-cycle rise/fall pulses for future interrupt logic.

Parameters:
- Width, 33, number of conditioned pad inputs; bits [31:0] are gpio, bit 32 is uart_rx.
- SyncStages, 2, synchroniser flops per bit; legal range 2..4.
- FilterCycles, 4, consecutive stable synchronised cycles required before the output changes; must be >= 1.
- ResetVal, {1'b1, 32'h0}, per-bit reset value of every synchroniser flop and every output level; uart_rx idles high.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  asynchronous, active-high reset.
- pad_din_i  input  Width  raw asynchronous pad inputs.
- filter_en_i  input  Width  per-bit enable; 1 = glitch filter active, 0 = bypass (sync only).
- din_o  output  Width  conditioned level to the core.
- rise_o  output  Width  one-cycle pulse on a 0->1 change of din_o.
- fall_o  output  Width  one-cycle pulse on a 1->0 change of din_o.

Behaviour:
- Reset (asynchronous assert):
  - all sync flops and din_o = ResetVal;
  - all filter counters = 0;
  - rise_o = fall_o = 0.
- Reset release is synchronous in effect: the first pad sample is taken on the first clk_i edge after rst_i falls.
- Synchroniser: per bit, a chain of SyncStages flops. s[i] is the last stage. There is no reset-free flop.
- Filter, per bit, counter cnt of width $clog2(FilterCycles+1). Each edge, evaluated in this priority:
  - filter_en_i[i]=0: din_o[i]<=s[i]; cnt<=0.
  - s[i]==din_o[i]: cnt<=0 (a glitch shorter than FilterCycles is discarded; the counter restarts).
  - cnt==FilterCycles-1: din_o[i]<=s[i]; cnt<=0.
  - otherwise: cnt<=cnt+1.
- Latency from the first edge sampling a new pad level to din_o changing:
  - filtered: SyncStages+FilterCycles cycles (6 at defaults);
  - bypass: SyncStages+1 cycles.
- FilterCycles=1 is equivalent to bypass.
- Edge pulses:
  - rise_o[i] is registered and high for exactly one cycle: the first cycle din_o[i] shows 1 after a change from 0.
  - fall_o[i] is the same for a 1->0 change.
  - A bit never asserts rise_o and fall_o together.
  - Successive changes of one bit are at least FilterCycles cycles apart when filtered, so pulses never merge.
- filter_en_i change mid-count:
  - to 0: the pending value (if s differs) is taken on that edge and cnt clears;
  - to 1: counting starts from 0 on the next mismatch.
- Bits are fully independent; simultaneous changes on any set of bits are processed in parallel.
- Reset mid-count: all state returns to reset values immediately, with no pulse generated.
- filter_en_i is quasi-static (driven from a CSR); it is not synchronised.

Decomposition:
- Package zerosoc_pad_pkg holds:
  - GpioWidth=32, PadInWidth=33, UartRxIdx=32;
  - PadInResetVal;
  - the pad-index map (we/no/ea/so bit ranges onto gpio indices) shared with the core top.
- Sub-module pad_filter_bit: one synchroniser chain plus counter plus edge registers for a single bit, parameterised by SyncStages, FilterCycles and ResetVal bit.
- pad_in_filter is a generate loop over Width instances.

Test Plan (all at defaults unless stated):
- Reset: hold rst_i, drive pad_din_i=0 -> din_o=33'h1_0000_0000 and rise_o=fall_o=0 throughout reset and for 2 cycles after release.
- Clean edge, filtered: gpio bit 3 goes 0->1 and holds -> din_o[3] rises exactly 6 cycles after the sampling edge; rise_o[3]=1 for that single cycle; all other bits unchanged.
- Glitch rejection: bit 10 pulses high for 3 synchronised cycles, then low -> din_o[10] stays 0; no rise_o/fall_o. Repeat with a 4-cycle pulse -> din_o[10] high for exactly 4 cycles; one rise_o and one fall_o pulse.
- Bypass: filter_en_i[32]=0, uart_rx toggles each 2 cycles -> din_o[32] follows with 3-cycle latency; fall_o/rise_o alternate each change.
- Mode switch mid-count: bit 0 high for 2 cycles filtered, then filter_en_i[0]=0 -> din_o[0] updates on that edge; cnt observed 0.
- Async reset mid-count: assert rst_i between clock edges while bit 5 is counting -> din_o[5] and counters clear immediately; no pulse after release.
